// File: rtl/calc_pkg.sv
// calc_pkg: shared opcodes and FSM encoding for the sequential calculator.
//   OP_ADDSUB / OP_MINMAX finish in one cycle; OP_MUL / OP_DIV iterate WIDTH cycles.
//   Codes 4..7 are illegal and produce res=0, err=1.
package calc_pkg;

  localparam logic [2:0] OP_ADDSUB = 3'd0;
  localparam logic [2:0] OP_MINMAX = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/calc_div_seq.sv
// calc_div_seq: unsigned restoring divider, one quotient bit per cycle, MSB first.
//   start    : load dividend/divisor (divisor must be non-zero)
//   dividend : numerator, divisor : denominator
//   quot/rem : result of the iteration performed in the current cycle; valid as
//              the final answer when done=1
//   done     : this cycle performs the last of WIDTH iterations
module calc_div_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   trial, diff;
  logic             qbit;
  logic [WIDTH-1:0] quo_it, rem_it;

  always_comb begin
    // trial needs WIDTH+1 bits: 2*rem+1 can exceed 2^WIDTH-1
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    qbit   = ~diff[WIDTH];  // no borrow => trial >= divisor
    rem_it = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_it = {quo_q[WIDTH-2:0], qbit};

    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = CNT_INIT;
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = quo_it;
      rem_d = rem_it;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  assign quot = quo_it;
  assign rem  = rem_it;
  assign done = busy_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/seq_calc.sv
// seq_calc: unsigned WIDTH-bit sequential calculator with valid/ready ports.
//   in_valid/in_ready : operand handshake (in_ready = FSM idle)
//   op, a, b          : opcode and operands, captured on accept
//   out_valid/out_ready: result handshake; result held until accepted
//   res               : {hi, lo} 2*WIDTH result
//   err               : divide-by-zero or illegal opcode
// ADDSUB/MINMAX/illegal/DIV-by-0 complete on the accept edge; MUL (shift-add,
// LSB first) and DIV (restoring, in calc_div_seq) take WIDTH BUSY cycles.
module seq_calc
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_mul_q, is_mul_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // product accumulator
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, shifted right each step
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   sum_w, dif_w;
  logic [2*WIDTH-1:0] mul_add;
  logic               div_start, div_done, last;
  logic [WIDTH-1:0]   div_quot, div_rem;

  calc_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign err       = err_q;

  always_comb begin
    sum_w    = a + b;
    dif_w    = a - b;
    mul_add  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last     = is_mul_q ? (cnt_q == '0) : div_done;

    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mul_d  = is_mul_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    res_d     = res_q;
    err_d     = err_q;
    div_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_ADDSUB: begin
              res_d   = {sum_w, dif_w};
              err_d   = 1'b0;
              state_d = S_DONE;
            end
            OP_MINMAX: begin
              res_d   = (a < b) ? {a, b} : {b, a};
              err_d   = 1'b0;
              state_d = S_DONE;
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              is_mul_d = 1'b1;
              cnt_d    = CNT_INIT;
              state_d  = S_BUSY;
            end
            OP_DIV: begin
              if (b == '0) begin
                res_d   = {{WIDTH{1'b1}}, a};
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                div_start = 1'b1;
                is_mul_d  = 1'b0;
                cnt_d     = CNT_INIT;
                state_d   = S_BUSY;
              end
            end
            default: begin
              res_d   = '0;
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (is_mul_q) begin
          acc_d    = mul_add;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last) begin
          // final iteration result goes straight into res
          res_d   = is_mul_q ? mul_add : {div_quot, div_rem};
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

endmodule
